// File: rtl/alu_execute_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_execute_unit
//  Description : LEGv8 execute stage: ALU-control decode, 64-bit ALU, PC+4 and
//                branch-target adders, next-PC select, one output register.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_execute_unit #(
    parameter int WIDTH   = 64,
    parameter int PC_INCR = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    input  logic [1:0]       alu_op,
    input  logic [10:0]      opcode,
    input  logic [WIDTH-1:0] reg_data_1,
    input  logic [WIDTH-1:0] reg_data_2,
    input  logic [WIDTH-1:0] sign_ext,
    input  logic             alu_src,
    input  logic             branch,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target,
    output logic             take_branch,
    output logic [WIDTH-1:0] next_pc
);

    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_ORR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_EOR  = 4'b0011;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_PASS = 4'b0111;
    localparam logic [3:0] c_ALU_NOR  = 4'b1100;
    localparam logic [3:0] c_ALU_ILL  = 4'b1111;

    localparam logic [10:0] c_OP_ADD = 11'b10001011000;
    localparam logic [10:0] c_OP_SUB = 11'b11001011000;
    localparam logic [10:0] c_OP_AND = 11'b10001010000;
    localparam logic [10:0] c_OP_ORR = 11'b10101010000;
    localparam logic [10:0] c_OP_EOR = 11'b11001010000;

    localparam int c_MSB = WIDTH - 1;

    logic [3:0]       w_ctrl;
    logic             w_illegal;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_overflow;
    logic             w_zero;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_branch_target;
    logic             w_take_branch;
    logic [WIDTH-1:0] w_next_pc;

    logic [3:0]       r_alu_ctrl;
    logic [WIDTH-1:0] r_alu_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_overflow;
    logic             r_illegal;
    logic [WIDTH-1:0] r_pc_plus4;
    logic [WIDTH-1:0] r_branch_target;
    logic             r_take_branch;
    logic [WIDTH-1:0] r_next_pc;

    // ALU control decode; alu_op 00 and 11 both mean address add.
    always_comb begin
        w_ctrl    = c_ALU_ADD;
        w_illegal = 1'b0;
        case (alu_op)
            2'b01: w_ctrl = c_ALU_PASS;
            2'b10: begin
                case (opcode)
                    c_OP_ADD: w_ctrl = c_ALU_ADD;
                    c_OP_SUB: w_ctrl = c_ALU_SUB;
                    c_OP_AND: w_ctrl = c_ALU_AND;
                    c_OP_ORR: w_ctrl = c_ALU_ORR;
                    c_OP_EOR: w_ctrl = c_ALU_EOR;
                    default: begin
                        w_ctrl    = c_ALU_ILL;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            default: w_ctrl = c_ALU_ADD;
        endcase
    end

    assign w_a    = reg_data_1;
    assign w_b    = alu_src ? sign_ext : reg_data_2;
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    // Subtraction as A + ~B + 1 so the carry-out reads as not-borrow.
    assign w_diff = {1'b0, w_a} + {1'b0, ~w_b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_result   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (w_ctrl)
            c_ALU_AND:  w_result = w_a & w_b;
            c_ALU_ORR:  w_result = w_a | w_b;
            c_ALU_EOR:  w_result = w_a ^ w_b;
            c_ALU_ADD: begin
                w_result   = w_sum[WIDTH-1:0];
                w_carry    = w_sum[WIDTH];
                w_overflow = (w_a[c_MSB] == w_b[c_MSB]) && (w_sum[c_MSB] != w_a[c_MSB]);
            end
            c_ALU_SUB: begin
                w_result   = w_diff[WIDTH-1:0];
                w_carry    = w_diff[WIDTH];
                w_overflow = (w_a[c_MSB] != w_b[c_MSB]) && (w_diff[c_MSB] != w_a[c_MSB]);
            end
            c_ALU_PASS: w_result = w_b;
            c_ALU_NOR:  w_result = ~(w_a | w_b);
            default:    w_result = '0;
        endcase
    end

    assign w_zero          = (w_result == '0);
    assign w_pc_plus4      = pc + WIDTH'(PC_INCR);
    assign w_branch_target = pc + (sign_ext << 2);
    assign w_take_branch   = branch & w_zero;
    assign w_next_pc       = w_take_branch ? w_branch_target : w_pc_plus4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_ctrl      <= '0;
            r_alu_result    <= '0;
            r_zero          <= 1'b0;
            r_carry         <= 1'b0;
            r_overflow      <= 1'b0;
            r_illegal       <= 1'b0;
            r_pc_plus4      <= '0;
            r_branch_target <= '0;
            r_take_branch   <= 1'b0;
            r_next_pc       <= '0;
        end else begin
            r_alu_ctrl      <= w_ctrl;
            r_alu_result    <= w_result;
            r_zero          <= w_zero;
            r_carry         <= w_carry;
            r_overflow      <= w_overflow;
            r_illegal       <= w_illegal;
            r_pc_plus4      <= w_pc_plus4;
            r_branch_target <= w_branch_target;
            r_take_branch   <= w_take_branch;
            r_next_pc       <= w_next_pc;
        end
    end

    assign alu_ctrl      = r_alu_ctrl;
    assign alu_result    = r_alu_result;
    assign zero          = r_zero;
    assign carry         = r_carry;
    assign overflow      = r_overflow;
    assign illegal       = r_illegal;
    assign pc_plus4      = r_pc_plus4;
    assign branch_target = r_branch_target;
    assign take_branch   = r_take_branch;
    assign next_pc       = r_next_pc;

endmodule
`default_nettype wire

// File: tb/tb_alu_execute_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_execute_unit
//  Description : Directed self-checking bench for alu_execute_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_execute_unit;

    localparam logic [10:0] c_OP_ADD = 11'b10001011000;
    localparam logic [10:0] c_OP_SUB = 11'b11001011000;
    localparam logic [10:0] c_OP_AND = 11'b10001010000;
    localparam logic [10:0] c_OP_ORR = 11'b10101010000;
    localparam logic [10:0] c_OP_EOR = 11'b11001010000;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc;
    logic [1:0]  alu_op;
    logic [10:0] opcode;
    logic [63:0] reg_data_1;
    logic [63:0] reg_data_2;
    logic [63:0] sign_ext;
    logic        alu_src;
    logic        branch;
    logic [3:0]  alu_ctrl;
    logic [63:0] alu_result;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        illegal;
    logic [63:0] pc_plus4;
    logic [63:0] branch_target;
    logic        take_branch;
    logic [63:0] next_pc;

    int pass_count  = 0;
    int check_count = 0;

    alu_execute_unit #(.WIDTH(64), .PC_INCR(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .alu_op        (alu_op),
        .opcode        (opcode),
        .reg_data_1    (reg_data_1),
        .reg_data_2    (reg_data_2),
        .sign_ext      (sign_ext),
        .alu_src       (alu_src),
        .branch        (branch),
        .alu_ctrl      (alu_ctrl),
        .alu_result    (alu_result),
        .zero          (zero),
        .carry         (carry),
        .overflow      (overflow),
        .illegal       (illegal),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .take_branch   (take_branch),
        .next_pc       (next_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b);
        alu_op = 2'b10; opcode = op; reg_data_1 = a; reg_data_2 = b;
        alu_src = 1'b0; branch = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pc = 64'h1234; alu_op = 2'b10; opcode = c_OP_SUB;
        reg_data_1 = 64'd9; reg_data_2 = 64'd9; sign_ext = 64'd3; alu_src = 1'b0; branch = 1'b1;
        step(); step();
        check_count++;
        if ({alu_ctrl, alu_result, zero, carry, overflow, illegal, pc_plus4, branch_target, take_branch} !== '0)
            $display("FAIL reset_outputs: got ctrl=%h res=%h z=%b c=%b v=%b ill=%b p4=%h bt=%h tb=%b, want all 0",
                     alu_ctrl, alu_result, zero, carry, overflow, illegal, pc_plus4, branch_target, take_branch);
        else pass_count++;
        check_count++;
        if (next_pc !== 64'd0) $display("FAIL reset_next_pc: got %h want 0", next_pc);
        else pass_count++;
        reset = 1'b0; pc = 64'd0; branch = 1'b0;
        set_r(c_OP_ADD, 64'd5, 64'd7);
        step();
        check_count++;
        if (pc_plus4 !== 64'd4) $display("FAIL release_pc_plus4: got %h want 4", pc_plus4);
        else pass_count++;
        check_count++;
        if (next_pc !== 64'd4) $display("FAIL release_next_pc: got %h want 4", next_pc);
        else pass_count++;
    endtask

    task automatic test_add();
        set_r(c_OP_ADD, 64'd5, 64'd7); step();
        check_count++;
        if ({alu_ctrl, alu_result, zero, carry, overflow, illegal} !== {4'b0010, 64'd12, 4'b0000})
            $display("FAIL add_5_7: got ctrl=%h res=%h z=%b c=%b v=%b, want 2/c/0/0/0", alu_ctrl, alu_result, zero, carry, overflow);
        else pass_count++;
        set_r(c_OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1); step();
        check_count++;
        if ({alu_result, zero, carry, overflow} !== {64'd0, 3'b110})
            $display("FAIL add_wrap: got res=%h z=%b c=%b v=%b, want 0/1/1/0", alu_result, zero, carry, overflow);
        else pass_count++;
        set_r(c_OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1); step();
        check_count++;
        if ({alu_result, carry, overflow} !== {64'h8000_0000_0000_0000, 2'b01})
            $display("FAIL add_ovf: got res=%h c=%b v=%b, want 8000000000000000/0/1", alu_result, carry, overflow);
        else pass_count++;
    endtask

    task automatic test_sub();
        set_r(c_OP_SUB, 64'h8000_0000_0000_0000, 64'd1); step();
        check_count++;
        if ({alu_ctrl, alu_result, carry, overflow} !== {4'b0110, 64'h7FFF_FFFF_FFFF_FFFF, 2'b11})
            $display("FAIL sub_ovf: got ctrl=%h res=%h c=%b v=%b, want 6/7fffffffffffffff/1/1", alu_ctrl, alu_result, carry, overflow);
        else pass_count++;
        set_r(c_OP_SUB, 64'd3, 64'd5); step();
        check_count++;
        if ({alu_result, zero, carry, overflow} !== {64'hFFFF_FFFF_FFFF_FFFE, 3'b000})
            $display("FAIL sub_borrow: got res=%h z=%b c=%b v=%b, want fffffffffffffffe/0/0/0", alu_result, zero, carry, overflow);
        else pass_count++;
        set_r(c_OP_SUB, 64'd42, 64'd42); step();
        check_count++;
        if ({alu_result, zero, carry} !== {64'd0, 2'b11})
            $display("FAIL sub_equal: got res=%h z=%b c=%b, want 0/1/1", alu_result, zero, carry);
        else pass_count++;
    endtask

    task automatic test_logic();
        set_r(c_OP_AND, 64'hF0, 64'h3C); step();
        check_count++;
        if ({alu_ctrl, alu_result, carry, overflow} !== {4'b0000, 64'h30, 2'b00})
            $display("FAIL and: got ctrl=%h res=%h c=%b v=%b, want 0/30/0/0", alu_ctrl, alu_result, carry, overflow);
        else pass_count++;
        set_r(c_OP_ORR, 64'hF0, 64'h3C); step();
        check_count++;
        if ({alu_ctrl, alu_result} !== {4'b0001, 64'hFC})
            $display("FAIL orr: got ctrl=%h res=%h, want 1/fc", alu_ctrl, alu_result);
        else pass_count++;
        set_r(c_OP_EOR, 64'hF0, 64'h3C); step();
        check_count++;
        if ({alu_ctrl, alu_result} !== {4'b0011, 64'hCC})
            $display("FAIL eor: got ctrl=%h res=%h, want 3/cc", alu_ctrl, alu_result);
        else pass_count++;
        set_r(11'b11111000010, 64'd5, 64'd7); step();
        check_count++;
        if ({alu_ctrl, illegal, alu_result, zero, carry, overflow} !== {4'b1111, 1'b1, 64'd0, 3'b100})
            $display("FAIL illegal: got ctrl=%h ill=%b res=%h z=%b c=%b v=%b, want f/1/0/1/0/0",
                     alu_ctrl, illegal, alu_result, zero, carry, overflow);
        else pass_count++;
    endtask

    task automatic test_branch();
        alu_op = 2'b01; opcode = 11'd0; branch = 1'b1; alu_src = 1'b0;
        reg_data_1 = 64'd77; reg_data_2 = 64'd0; pc = 64'h100; sign_ext = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        check_count++;
        if ({alu_ctrl, zero, take_branch, branch_target, next_pc} !== {4'b0111, 2'b11, 64'hF8, 64'hF8})
            $display("FAIL cbz_taken: got ctrl=%h z=%b tb=%b bt=%h npc=%h, want 7/1/1/f8/f8",
                     alu_ctrl, zero, take_branch, branch_target, next_pc);
        else pass_count++;
        reg_data_2 = 64'd3; step();
        check_count++;
        if ({alu_result, take_branch, pc_plus4, next_pc} !== {64'd3, 1'b0, 64'h104, 64'h104})
            $display("FAIL cbz_not_taken: got res=%h tb=%b p4=%h npc=%h, want 3/0/104/104",
                     alu_result, take_branch, pc_plus4, next_pc);
        else pass_count++;
        branch = 1'b0; reg_data_2 = 64'd0; step();
        check_count++;
        if ({zero, take_branch, next_pc} !== {2'b10, 64'h104})
            $display("FAIL nobranch_zero: got z=%b tb=%b npc=%h, want 1/0/104", zero, take_branch, next_pc);
        else pass_count++;
        pc = 64'hFFFF_FFFF_FFFF_FFFC; sign_ext = 64'h4000_0000_0000_0001; branch = 1'b1; step();
        check_count++;
        if ({pc_plus4, branch_target, next_pc} !== {64'd0, 64'h0, 64'h0})
            $display("FAIL pc_wrap: got p4=%h bt=%h npc=%h, want 0/0/0", pc_plus4, branch_target, next_pc);
        else pass_count++;
    endtask

    task automatic test_mem_addr();
        alu_op = 2'b00; opcode = c_OP_SUB; alu_src = 1'b1; branch = 1'b0; pc = 64'h200;
        reg_data_1 = 64'h1000; reg_data_2 = 64'h5; sign_ext = 64'hFFFF_FFFF_FFFF_FFF8;
        step();
        check_count++;
        if ({alu_ctrl, alu_result, carry, overflow, illegal} !== {4'b0010, 64'hFF8, 3'b100})
            $display("FAIL ldur_addr: got ctrl=%h res=%h c=%b v=%b ill=%b, want 2/ff8/1/0/0",
                     alu_ctrl, alu_result, carry, overflow, illegal);
        else pass_count++;
        alu_op = 2'b11; sign_ext = 64'h10; step();
        check_count++;
        if ({alu_ctrl, alu_result, carry} !== {4'b0010, 64'h1010, 1'b0})
            $display("FAIL aluop11_add: got ctrl=%h res=%h c=%b, want 2/1010/0", alu_ctrl, alu_result, carry);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        set_r(c_OP_ADD, 64'd1, 64'd2); step();
        check_count++;
        if (alu_result !== 64'd3) $display("FAIL b2b_0: got %h want 3", alu_result);
        else pass_count++;
        set_r(c_OP_SUB, 64'd10, 64'd4); step();
        check_count++;
        if (alu_result !== 64'd6) $display("FAIL b2b_1: got %h want 6", alu_result);
        else pass_count++;
        set_r(c_OP_EOR, 64'hAA, 64'h55); step();
        check_count++;
        if (alu_result !== 64'hFF) $display("FAIL b2b_2: got %h want ff", alu_result);
        else pass_count++;
    endtask

    task automatic test_mid_reset();
        set_r(c_OP_ADD, 64'd100, 64'd23); pc = 64'h40; step();
        check_count++;
        if ({alu_result, next_pc} !== {64'd123, 64'h44})
            $display("FAIL pre_reset: got res=%h npc=%h, want 7b/44", alu_result, next_pc);
        else pass_count++;
        reset = 1'b1; step();
        check_count++;
        if ({alu_ctrl, alu_result, zero, carry, overflow, illegal, pc_plus4, branch_target, take_branch, next_pc} !== '0)
            $display("FAIL mid_reset: got ctrl=%h res=%h z=%b p4=%h npc=%h, want all 0",
                     alu_ctrl, alu_result, zero, pc_plus4, next_pc);
        else pass_count++;
        reset = 1'b0; step();
        check_count++;
        if ({alu_result, next_pc} !== {64'd123, 64'h44})
            $display("FAIL post_reset: got res=%h npc=%h, want 7b/44", alu_result, next_pc);
        else pass_count++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_branch();
        test_mem_addr();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
`default_nettype wire
